// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic-array sequencer and its operand buffers.
package systolic_pkg;

   localparam int DW    = 8;
   localparam int N_MAX = 16;
   // Step counter covers 2N-1 feed steps and N+PE_LAT-1 drain steps with headroom.
   localparam int T_W   = $clog2(2 * N_MAX) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/systolic_opbuf.sv
// NxN operand register file with one write port and a diagonal read.
// Lane k of the diagonal at step t reads element (k, t-k) for the A side and
// (t-k, k) for the B side; lanes outside the valid diagonal read as zero.
module systolic_opbuf #(
   parameter int N      = 4,
   parameter int DW     = systolic_pkg::DW,
   parameter bit B_SIDE = 1'b0
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [$clog2(N)-1:0]        row,
   input  logic [$clog2(N)-1:0]        col,
   input  logic [DW-1:0]               wdata,
   input  logic [systolic_pkg::T_W-1:0] t,
   output logic [N*DW-1:0]             diag
);
   import systolic_pkg::*;

   localparam int IW = $clog2(N);

   logic [DW-1:0]  mem [N][N];
   logic [T_W-1:0] d;

   // Element write; contents survive reset so the host need not reload.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[row][col] <= wdata;
      end
   end

   // Diagonal wavefront for step t.
   always_comb begin
      diag = '0;
      d    = '0;
      for (int k = 0; k < N; k++) begin
         d = t - T_W'(k);
         if ((t >= T_W'(k)) && (d < T_W'(N))) begin
            if (B_SIDE) begin
               diag[k*DW +: DW] = mem[d[IW-1:0]][k];
            end else begin
               diag[k*DW +: DW] = mem[k][d[IW-1:0]];
            end
         end
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN fp8 systolic array: holds A/B, feeds the skewed
// wavefront into the west/north edges, times the drain and strobes capture.
// Optional build macro SYS_CTRL_PERF_EN adds the perf_cyc operation-cycle counter.
module systolic_seq_ctrl #(
   parameter int N      = 4,
   parameter int DW     = systolic_pkg::DW,
   parameter int PE_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [$clog2(N)-1:0] wr_row,
   input  logic [$clog2(N)-1:0] wr_col,
   input  logic [DW-1:0]        wr_data,
   output logic                 wr_rej,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [N*DW-1:0]      a_edge,
   output logic [N*DW-1:0]      b_edge,
   output logic                 cap_en,
`ifdef SYS_CTRL_PERF_EN
   output logic [15:0]          perf_cyc,
`endif
   output logic [$clog2(N)-1:0] cap_idx
);
   import systolic_pkg::*;

   // Last step index of each phase, and the drain step where results start emerging.
   localparam logic [T_W-1:0] FEED_LAST  = T_W'(2 * N - 2);
   localparam logic [T_W-1:0] DRAIN_LAST = T_W'(N + PE_LAT - 2);
   localparam logic [T_W-1:0] CAP_FIRST  = T_W'(PE_LAT - 1);

   state_t         state;
   logic [T_W-1:0] t;
   logic [T_W-1:0] t_nx;
   logic [N*DW-1:0] a_diag;
   logic [N*DW-1:0] b_diag;
   logic           wr_ok;

   assign t_nx  = t + 1'b1;
   // Writes land only while idle; a write that coincides with start still
   // commits at that edge, so the first FEED step already sees it.
   assign wr_ok = wr_en && (state == IDLE);

   systolic_opbuf #(.N(N), .DW(DW), .B_SIDE(1'b0)) u_abuf (
      .clk   (clk),
      .we    (wr_ok && !wr_sel),
      .row   (wr_row),
      .col   (wr_col),
      .wdata (wr_data),
      .t     (t),
      .diag  (a_diag)
   );

   systolic_opbuf #(.N(N), .DW(DW), .B_SIDE(1'b1)) u_bbuf (
      .clk   (clk),
      .we    (wr_ok && wr_sel),
      .row   (wr_row),
      .col   (wr_col),
      .wdata (wr_data),
      .t     (t),
      .diag  (b_diag)
   );

   // Sequencer FSM with registered handshake, edge and capture outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         t       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_rej  <= 1'b0;
         cap_en  <= 1'b0;
         cap_idx <= '0;
         a_edge  <= '0;
         b_edge  <= '0;
      end else begin
         wr_rej <= wr_en && (state != IDLE);
         done   <= 1'b0;
         case (state)
            IDLE: begin
               a_edge  <= '0;
               b_edge  <= '0;
               cap_en  <= 1'b0;
               cap_idx <= '0;
               if (start) begin
                  state <= FEED;
                  t     <= '0;
                  busy  <= 1'b1;
               end
            end
            FEED: begin
               // Step t's diagonal appears on the edges one clock later.
               a_edge <= a_diag;
               b_edge <= b_diag;
               if (t == FEED_LAST) begin
                  state   <= DRAIN;
                  t       <= '0;
                  cap_en  <= (CAP_FIRST == '0);
                  cap_idx <= '0;
               end else begin
                  t <= t_nx;
               end
            end
            DRAIN: begin
               a_edge <= '0;
               b_edge <= '0;
               if (t == DRAIN_LAST) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cap_en  <= 1'b0;
                  cap_idx <= '0;
               end else begin
                  // Capture window covers the final N drain cycles.
                  t       <= t_nx;
                  cap_en  <= (t_nx >= CAP_FIRST);
                  cap_idx <= cap_en ? cap_idx + 1'b1 : '0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SYS_CTRL_PERF_EN
   // Clocks from start acceptance through DONE, saturating; held while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cyc <= '0;
      end else if ((state == IDLE) && start) begin
         perf_cyc <= 16'd1;
      end else if ((state != IDLE) && (perf_cyc != 16'hFFFF)) begin
         perf_cyc <= perf_cyc + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (N=4, PE_LAT=2).
// Expected edges, handshake and capture timing come from a cycle-indexed
// model of the operation: phase lengths and diagonal indexing by arithmetic.
module tb_systolic_seq_ctrl;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int PE_LAT    = 2;
   localparam int IW        = $clog2(N);
   localparam int FEED_CYC  = 2 * N - 1;
   localparam int DRAIN_CYC = N + PE_LAT - 1;
   localparam int BUSY_END  = FEED_CYC + DRAIN_CYC;   // last busy cycle after start edge
   localparam int DONE_C    = BUSY_END + 1;           // done cycle after start edge
   localparam int LAT       = 1 + DONE_C;             // start-sampled cycle counted as 1
   localparam int CAP_START = BUSY_END - N + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic            wr_sel;
   logic [IW-1:0]   wr_row;
   logic [IW-1:0]   wr_col;
   logic [DW-1:0]   wr_data;
   logic            wr_rej;
   logic            start;
   logic            busy;
   logic            done;
   logic [N*DW-1:0] a_edge;
   logic [N*DW-1:0] b_edge;
   logic            cap_en;
   logic [IW-1:0]   cap_idx;
`ifdef SYS_CTRL_PERF_EN
   logic [15:0]     perf_cyc;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ma [N][N];
   logic [DW-1:0] mb [N][N];

   always #5 clk = ~clk;

   systolic_seq_ctrl #(.N(N), .DW(DW), .PE_LAT(PE_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_row   (wr_row),
      .wr_col   (wr_col),
      .wr_data  (wr_data),
      .wr_rej   (wr_rej),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .a_edge   (a_edge),
      .b_edge   (b_edge),
      .cap_en   (cap_en),
`ifdef SYS_CTRL_PERF_EN
      .perf_cyc (perf_cyc),
`endif
      .cap_idx  (cap_idx)
   );

   task automatic chk(input string tag, input string sig, input int cyc,
                      input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s.%s cyc=%0d observed=%0h expected=%0h", tag, sig, cyc, obs, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // West-edge value c cycles after the start edge: step c-2's diagonal.
   function automatic logic [N*DW-1:0] exp_a(input int c);
      logic [N*DW-1:0] v;
      int s;
      v = '0;
      s = c - 2;
      for (int i = 0; i < N; i++) begin
         if ((s - i >= 0) && (s - i < N)) v[i*DW +: DW] = ma[i][s-i];
      end
      return v;
   endfunction

   function automatic logic [N*DW-1:0] exp_b(input int c);
      logic [N*DW-1:0] v;
      int s;
      v = '0;
      s = c - 2;
      for (int j = 0; j < N; j++) begin
         if ((s - j >= 0) && (s - j < N)) v[j*DW +: DW] = mb[s-j][j];
      end
      return v;
   endfunction

   task automatic load(input bit sel, input int r, input int cc, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = IW'(r);
      wr_col  = IW'(cc);
      wr_data = d;
      tick;
      wr_en = 1'b0;
      if (sel) mb[r][cc] = d;
      else     ma[r][cc] = d;
      chk("load", "wr_rej", 0, 64'(wr_rej), 64'(0));
   endtask

   task automatic start_op(input bit hold);
      start = 1'b1;
      tick;
      if (!hold) start = 1'b0;
   endtask

   // Checks one operation from cycle 1 (first cycle after the start edge)
   // through the idle cycle following done. wr_at > 0 injects a write there.
   task automatic trace(input int wr_at, input string tag);
      bit in_cap;
      for (int c = 1; c <= DONE_C + 1; c++) begin
         in_cap = (c >= CAP_START) && (c <= BUSY_END);
         chk(tag, "busy",   c, 64'(busy),   64'(c <= BUSY_END));
         chk(tag, "done",   c, 64'(done),   64'(c == DONE_C));
         chk(tag, "a_edge", c, 64'(a_edge), 64'(exp_a(c)));
         chk(tag, "b_edge", c, 64'(b_edge), 64'(exp_b(c)));
         chk(tag, "cap_en", c, 64'(cap_en), 64'(in_cap));
         chk(tag, "wr_rej", c, 64'(wr_rej), 64'((wr_at > 0) && (c == wr_at + 1)));
         if (in_cap) chk(tag, "cap_idx", c, 64'(cap_idx), 64'(c - CAP_START));
         if (c == wr_at) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_row  = '0;
            wr_col  = '0;
            wr_data = ~ma[0][0];
         end
         if (c <= DONE_C) begin
            tick;
            wr_en = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; wr_en = 1'b0; wr_sel = 1'b0;
      wr_row = '0; wr_col = '0; wr_data = '0;

      // Reset held two cycles with start asserted.
      tick;
      tick;
      chk("rst", "busy",    0, 64'(busy),    64'(0));
      chk("rst", "done",    0, 64'(done),    64'(0));
      chk("rst", "wr_rej",  0, 64'(wr_rej),  64'(0));
      chk("rst", "cap_en",  0, 64'(cap_en),  64'(0));
      chk("rst", "cap_idx", 0, 64'(cap_idx), 64'(0));
      chk("rst", "a_edge",  0, 64'(a_edge),  64'(0));
      chk("rst", "b_edge",  0, 64'(b_edge),  64'(0));
`ifdef SYS_CTRL_PERF_EN
      chk("rst", "perf_cyc", 0, 64'(perf_cyc), 64'(0));
`endif
      rst = 1'b0; start = 1'b0;
      tick;
      chk("rst_rel", "busy",   0, 64'(busy),   64'(0));
      chk("rst_rel", "a_edge", 0, 64'(a_edge), 64'(0));

      // Directed operands: small A block in the corner, fp8 identity for B.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            load(1'b0, i, j, (i < 2 && j < 2) ? DW'(8'h38 + 8'(4 * (2 * i + j))) : '0);
            load(1'b1, i, j, (i == j) ? 8'h38 : 8'h00);
         end
      end
      start_op(1'b0);
      trace(0, "dir");

      // Random operand sets.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               load(1'b0, i, j, DW'($urandom));
               load(1'b1, i, j, DW'($urandom));
            end
         end
         start_op(1'b0);
         trace(0, "rnd");
      end

      // Write while feeding is rejected; next run must still use the old A.
      start_op(1'b0);
      trace(3, "rej");
      start_op(1'b0);
      trace(0, "rej_after");

      // Write and start in the same cycle: FEED sees the new element.
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'h3C;
      start = 1'b1;
      tick;
      wr_en = 1'b0; start = 1'b0;
      ma[0][0] = 8'h3C;
      tick;
      chk("wr_start", "a_row0", 2, 64'(a_edge[DW-1:0]), 64'(8'h3C));
      for (int k = 0; k < DONE_C; k++) tick;

      // Reset at FEED step 1 aborts: idle, zero edges, never a done pulse.
      start_op(1'b0);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort", "busy",   0, 64'(busy),   64'(0));
      chk("abort", "done",   0, 64'(done),   64'(0));
      chk("abort", "a_edge", 0, 64'(a_edge), 64'(0));
      chk("abort", "b_edge", 0, 64'(b_edge), 64'(0));
      chk("abort", "cap_en", 0, 64'(cap_en), 64'(0));
      for (int k = 1; k <= LAT + 2; k++) begin
         tick;
         chk("abort", "done", k, 64'(done), 64'(0));
         chk("abort", "busy", k, 64'(busy), 64'(0));
      end
      start_op(1'b0);
      trace(0, "post_abort");

      // start held high: back-to-back operations, one every LAT cycles.
      start_op(1'b1);
      trace(0, "b2b1");
`ifdef SYS_CTRL_PERF_EN
      chk("b2b1", "perf_cyc", 0, 64'(perf_cyc), 64'(LAT));
`endif
      tick;
      start = 1'b0;
      trace(0, "b2b2");
`ifdef SYS_CTRL_PERF_EN
      chk("b2b2", "perf_cyc", 0, 64'(perf_cyc), 64'(LAT));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
